aes_sbox_arbiter: RTL and testbench

Time-multiplexes the single shared 32-bit AES S-box (four parallel byte lookups, combinational) between two requesters: the key-expansion engine (requester 0) and the encipher round block (requester 1). It sits between those two blocks and the `aes_sbox` instance in the AES core. It grants exclusive S-box ownership through a registered, round-robin request/grant handshake with grant locking. The owner's word is muxed to the S-box and the substituted word is returned to the owner in the same cycle.

---
 rtl/aes_sbox_arb_pkg.sv | 10 +
 rtl/aes_sbox_arbiter.sv | 74 +++++++
 tb/tb_aes_sbox_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_sbox_arb_pkg.sv
// aes_sbox_arb_pkg: shared state encoding, requester IDs and defaults for the S-box arbiter.
package aes_sbox_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} arb_state_e;
  localparam logic REQ_KEYMEM   = 1'b0;
  localparam logic REQ_ENCIPHER = 1'b1;
  localparam int   MAX_HOLD_DEF = 16;
  function automatic arb_state_e grant_of(input logic id);
    return id ? GRANT1 : GRANT0;
  endfunction
endpackage

// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter: round-robin, grant-locking owner of the shared AES S-box.
// Optional hold-timeout preemption is enabled by defining AES_SBOX_ARB_TIMEOUT_EN.
module aes_sbox_arbiter
  import aes_sbox_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [31:0] sboxw0,
  output logic        gnt0,
  output logic [31:0] new_sboxw0,
  input  logic        req1,
  input  logic [31:0] sboxw1,
  output logic        gnt1,
  output logic [31:0] new_sboxw1,
  output logic [31:0] sbox_in,
  input  logic [31:0] sbox_out,
  output logic        preempt
);
  if (MAX_HOLD < 2 || MAX_HOLD > 31) begin : g_bad_max_hold
    $error("aes_sbox_arbiter: MAX_HOLD must be in 2..31");
  end
  arb_state_e state_q, state_d, other;
  logic       last_q, last_d;
  logic       preempt_q, preempt_d;
  logic       own_req, oth_req, timeout;
`ifdef AES_SBOX_ARB_TIMEOUT_EN
  localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);
  logic [4:0] cnt_q, cnt_d;
  assign timeout = (cnt_q == HOLD_LAST) && oth_req;
  assign cnt_d   = (state_d != state_q || state_q == IDLE || !oth_req) ? 5'd0 : cnt_q + 5'd1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= 5'd0;
    else          cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    own_req   = (state_q == GRANT1) ? req1 : req0;
    oth_req   = (state_q == GRANT1) ? req0 : req1;
    other     = (state_q == GRANT0) ? GRANT1 : GRANT0;
    state_d   = state_q;
    preempt_d = 1'b0;
    if (state_q == IDLE)
      state_d = (req0 && req1) ? grant_of(!last_q) : req0 ? GRANT0 : req1 ? GRANT1 : IDLE;
    else if (!own_req)
      state_d = oth_req ? other : IDLE;
    else if (timeout) begin
      state_d   = other;
      preempt_d = 1'b1;
    end
    last_d = (state_d == GRANT0) ? REQ_KEYMEM : (state_d == GRANT1) ? REQ_ENCIPHER : last_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_q    <= REQ_ENCIPHER;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      preempt_q <= preempt_d;
    end
  end
  assign gnt0       = (state_q == GRANT0);
  assign gnt1       = (state_q == GRANT1);
  assign preempt    = preempt_q;
  assign sbox_in    = gnt0 ? sboxw0 : gnt1 ? sboxw1 : 32'd0;
  assign new_sboxw0 = sbox_out & {32{gnt0}};
  assign new_sboxw1 = sbox_out & {32{gnt1}};
endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// tb_aes_sbox_arbiter: directed checks of grant sequencing, data isolation and reset.
module tb_aes_sbox_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1;
  logic [31:0] sboxw0, sboxw1;
  logic        gnt0, gnt1, preempt;
  logic [31:0] new_sboxw0, new_sboxw1, sbox_in, sbox_out;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] b);
    case (b)
      8'h00: return 8'h63;
      8'h01: return 8'h7c;
      8'h02: return 8'h77;
      8'h03: return 8'h7b;
      8'h04: return 8'hf2;
      8'h10: return 8'hca;
      8'h11: return 8'h82;
      8'hff: return 8'h16;
      default: return 8'h00;
    endcase
  endfunction

  assign sbox_out = {sb(sbox_in[31:24]), sb(sbox_in[23:16]), sb(sbox_in[15:8]), sb(sbox_in[7:0])};

  aes_sbox_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .sboxw0(sboxw0), .gnt0(gnt0), .new_sboxw0(new_sboxw0),
    .req1(req1), .sboxw1(sboxw1), .gnt1(gnt1), .new_sboxw1(new_sboxw1),
    .sbox_in(sbox_in), .sbox_out(sbox_out), .preempt(preempt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; sboxw0 = 32'h0; sboxw1 = 32'h0;
    #12;
    checks++;
    if ({gnt0, gnt1, preempt} !== 3'b000) begin
      errors++; $display("FAIL reset_grants got %b want 000", {gnt0, gnt1, preempt});
    end
    checks++;
    if ({sbox_in, new_sboxw0, new_sboxw1} !== 96'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h want 0", sbox_in, new_sboxw0, new_sboxw1);
    end
    @(negedge clk) reset_n = 1'b1;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin
      errors++; $display("FAIL reset_idle got %b want 00", {gnt0, gnt1});
    end
  endtask

  task automatic test_single();
    req1 = 1'b1; sboxw1 = 32'h00010203;
    #1;
    checks++;
    if (gnt1 !== 1'b0 || new_sboxw1 !== 32'h0) begin
      errors++; $display("FAIL single_latency gnt1=%b new=%h want 0 0", gnt1, new_sboxw1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || new_sboxw1 !== 32'h637c777b || new_sboxw0 !== 32'h0
          || sbox_in !== 32'h00010203) begin
        errors++;
        $display("FAIL single_grant cyc%0d gnt0=%b gnt1=%b new1=%h new0=%h in=%h want 0 1 637c777b 0 00010203",
                 i, gnt0, gnt1, new_sboxw1, new_sboxw0, sbox_in);
      end
    end
    req1 = 1'b0;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin
      errors++; $display("FAIL single_release got %b want 00", {gnt0, gnt1});
    end
  endtask

  task automatic test_isolation();
    sboxw0 = 32'hffffffff;
    #1;
    checks++;
    if (sbox_in !== 32'h0 || new_sboxw0 !== 32'h0 || new_sboxw1 !== 32'h0) begin
      errors++; $display("FAIL isolation in=%h new0=%h new1=%h want 0 0 0", sbox_in, new_sboxw0, new_sboxw1);
    end
  endtask

  task automatic test_tie_handover();
    req0 = 1'b1; req1 = 1'b1; sboxw0 = 32'h04ff1011; sboxw1 = 32'h00010203;
    tick();
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || new_sboxw0 !== 32'hf216ca82 || new_sboxw1 !== 32'h0) begin
      errors++; $display("FAIL tie_first gnt0=%b gnt1=%b new0=%h new1=%h want 1 0 f216ca82 0",
                         gnt0, gnt1, new_sboxw0, new_sboxw1);
    end
    tick();
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++; $display("FAIL tie_lock gnt0=%b want 1", gnt0);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || new_sboxw1 !== 32'h637c777b) begin
      errors++; $display("FAIL handover gnt0=%b gnt1=%b new1=%h want 0 1 637c777b", gnt0, gnt1, new_sboxw1);
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    req0 = 1'b1;
    tick();
    tick();
    req0 = 1'b0;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin
      errors++; $display("FAIL rr_idle got %b want 00", {gnt0, gnt1});
    end
    req0 = 1'b1; req1 = 1'b1;
    tick();
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
      errors++; $display("FAIL rr_tie gnt0=%b gnt1=%b want 0 1", gnt0, gnt1);
    end
    req1 = 1'b0;
    tick();
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL rr_back gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
    end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    req1 = 1'b1;
    tick();
    checks++;
    if (gnt1 !== 1'b1) begin
      errors++; $display("FAIL mid_pre gnt1=%b want 1", gnt1);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (gnt1 !== 1'b0 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL mid_async gnt0=%b gnt1=%b want 0 0", gnt0, gnt1);
    end
    req1 = 1'b0; req0 = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    tick();
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL mid_restart gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
    end
  endtask

  task automatic test_timeout();
    req1 = 1'b1;
`ifdef AES_SBOX_ARB_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (i < 4 && (gnt0 !== 1'b1 || preempt !== 1'b0)) begin
        errors++; $display("FAIL timeout_hold cyc%0d gnt0=%b preempt=%b want 1 0", i, gnt0, preempt);
      end else if (i == 4 && (gnt0 !== 1'b0 || gnt1 !== 1'b1 || preempt !== 1'b1)) begin
        errors++; $display("FAIL timeout_fire gnt0=%b gnt1=%b preempt=%b want 0 1 1", gnt0, gnt1, preempt);
      end
    end
    tick();
    checks++;
    if (preempt !== 1'b0 || gnt1 !== 1'b1) begin
      errors++; $display("FAIL timeout_pulse preempt=%b gnt1=%b want 0 1", preempt, gnt1);
    end
`else
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || preempt !== 1'b0) begin
        errors++; $display("FAIL no_timeout cyc%0d gnt0=%b gnt1=%b preempt=%b want 1 0 0", i, gnt0, gnt1, preempt);
      end
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL no_timeout_release gnt0=%b gnt1=%b want 0 1", gnt0, gnt1);
    end
`endif
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_isolation();
    test_tie_handover();
    test_round_robin();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
